// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, owner codes and data width.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
package mem_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DEV  = 2'b10
    } owner_t;

    // The requester that did not hold the previous grant.
    function automatic owner_t other_port(input owner_t last);
        return (last == OWN_CPU) ? OWN_DEV : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way winner select for mem_arbiter.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port that was not granted last; otherwise CPU wins ties.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dev_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (cpu_req && dev_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = other_port(last_owner);
`else
            winner = OWN_CPU;
`endif
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dev_req) begin
            winner = OWN_DEV;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous single-port RAM between the CPU (priority) and a device port.
// Build macro MEM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking via last_owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = WORD_W
)(
    input  logic                  clock_input,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dev_req,
    input  logic                  dev_we,
    input  logic [ADDR_WIDTH-1:0] dev_addr,
    input  logic [DATA_WIDTH-1:0] dev_wdata,
    output logic                  dev_ack,
    output logic [DATA_WIDTH-1:0] dev_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [1:0]            owner
);

    state_t                state;
    owner_t                owner_q;
    owner_t                winner;
    logic                  acc_we;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dev_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t                last_owner;
`endif

    arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dev_req    (dev_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .winner     (winner)
    );

    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner_q     <= OWN_NONE;
            acc_we      <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_ack     <= 1'b0;
            dev_ack     <= 1'b0;
            cpu_rdata_q <= '0;
            dev_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner  <= OWN_DEV;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dev_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Capture the winner's access; later request changes are ignored.
                    if (winner != OWN_NONE) begin
                        owner_q <= winner;
                        mem_en  <= 1'b1;
                        if (winner == OWN_CPU) begin
                            acc_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            acc_we    <= dev_we;
                            mem_we    <= dev_we;
                            mem_addr  <= dev_addr;
                            mem_wdata <= dev_wdata;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner <= winner;
`endif
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    cpu_ack <= (owner_q == OWN_CPU);
                    dev_ack <= (owner_q == OWN_DEV);
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (!acc_we) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_q <= mem_rdata;
                        end else if (owner_q == OWN_DEV) begin
                            dev_rdata_q <= mem_rdata;
                        end
                    end
                    owner_q <= OWN_NONE;
                    state   <= ST_IDLE;
                end
                default: begin
                    owner_q <= OWN_NONE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in the ack cycle itself, so forward it there and hold it afterwards.
    assign cpu_rdata = (cpu_ack && !acc_we) ? mem_rdata : cpu_rdata_q;
    assign dev_rdata = (dev_ack && !acc_we) ? mem_rdata : dev_rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dev_req, dev_we;
    logic [AW-1:0] cpu_addr, dev_addr;
    logic [DW-1:0] cpu_wdata, dev_wdata;
    logic          cpu_ack, dev_ack;
    logic [DW-1:0] cpu_rdata, dev_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    owner;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_cpu_rd = '0;
    logic [DW-1:0] exp_dev_rd = '0;

    typedef struct {
        bit            port;    // 0 = cpu, 1 = dev
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;   // expected read data
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clock_input (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .dev_req     (dev_req),
        .dev_we      (dev_we),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_ack     (dev_ack),
        .dev_rdata   (dev_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .owner       (owner)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input string nm);
        logic [1:0] own;
        own = port ? 2'b10 : 2'b01;
        if (port) begin
            dev_req = 1'b1; dev_we = we; dev_addr = addr; dev_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        step();
        chk({nm, " strobe mem_en"}, 32'(mem_en), 32'(1));
        chk({nm, " strobe mem_we"}, 32'(mem_we), 32'(we));
        chk({nm, " strobe mem_addr"}, 32'(mem_addr), 32'(addr));
        if (we) chk({nm, " strobe mem_wdata"}, 32'(mem_wdata), 32'(wd));
        chk({nm, " strobe owner"}, 32'(owner), 32'(own));
        chk({nm, " strobe acks"}, 32'({cpu_ack, dev_ack}), 32'(0));
        step();
        chk({nm, " ack cpu"}, 32'(cpu_ack), 32'(!port));
        chk({nm, " ack dev"}, 32'(dev_ack), 32'(port));
        chk({nm, " ack mem_en"}, 32'(mem_en), 32'(0));
        if (!we) begin
            if (port) exp_dev_rd = exp_rd;
            else      exp_cpu_rd = exp_rd;
            chk({nm, " ack rdata"}, 32'(port ? dev_rdata : cpu_rdata), 32'(exp_rd));
        end
        cpu_req = 1'b0;
        dev_req = 1'b0;
        step();
        chk({nm, " idle owner"}, 32'(owner), 32'(0));
        chk({nm, " idle acks"}, 32'({cpu_ack, dev_ack}), 32'(0));
        chk({nm, " cpu_rdata hold"}, 32'(cpu_rdata), 32'(exp_cpu_rd));
        chk({nm, " dev_rdata hold"}, 32'(dev_rdata), 32'(exp_dev_rd));
    endtask

    initial begin
        bit rr;
        bit exp_c, exp_d;
        int k;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        vecs[0] = '{1'b0, 1'b1, 13'h0005, 16'h1ABC, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 13'h0005, 16'h0000, 16'h1ABC};
        vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 16'hABCD, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 16'h0000, 16'hABCD};
        vecs[4] = '{1'b0, 1'b0, 13'h1FFF, 16'h0000, 16'hABCD};
        vecs[5] = '{1'b1, 1'b1, 13'h0000, 16'hFFFF, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 13'h0000, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b0, 1'b1, 13'h0005, 16'h0000, 16'h0000};
        vecs[8] = '{1'b0, 1'b0, 13'h0005, 16'h0000, 16'h0000};

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dev_req = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0;
        step();
        step();
        chk("reset mem_en/we", 32'({mem_en, mem_we}), 32'(0));
        chk("reset owner", 32'(owner), 32'(0));
        chk("reset acks", 32'({cpu_ack, dev_ack}), 32'(0));
        chk("reset mem_addr", 32'(mem_addr), 32'(0));
        chk("reset rdata", 32'({cpu_rdata, dev_rdata}), 32'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                   $sformatf("vec%0d", i));
        end

        // Simultaneous requests; last grant was the CPU.
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0010; cpu_wdata = 16'h1111;
        dev_req = 1; dev_we = 1; dev_addr = 13'h0011; dev_wdata = 16'h2222;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_c = (c == (rr ? 5 : 2));
            exp_d = (c == (rr ? 2 : 5));
            chk($sformatf("tie c%0d cpu_ack", c), 32'(cpu_ack), 32'(exp_c));
            chk($sformatf("tie c%0d dev_ack", c), 32'(dev_ack), 32'(exp_d));
            if (exp_c) cpu_req = 1'b0;
            if (exp_d) dev_req = 1'b0;
        end
        access(1'b0, 1'b0, 13'h0010, 16'h0000, 16'h1111, "tie rd cpu");
        access(1'b1, 1'b0, 13'h0011, 16'h0000, 16'h2222, "tie rd dev");

        // Both held continuously; last grant was the device.
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0005;
        dev_req = 1; dev_we = 0; dev_addr = 13'h0000;
        for (int c = 1; c <= 12; c++) begin
            step();
            k = (c - 2) / 3;
            exp_c = (c % 3 == 2) && (!rr || (k % 2 == 0));
            exp_d = (c % 3 == 2) && rr && (k % 2 == 1);
            chk($sformatf("held c%0d cpu_ack", c), 32'(cpu_ack), 32'(exp_c));
            chk($sformatf("held c%0d dev_ack", c), 32'(dev_ack), 32'(exp_d));
        end
        cpu_req = 0;
        dev_req = 0;
        step();
        step();
        exp_cpu_rd = 16'h0000;
        if (rr) exp_dev_rd = 16'hFFFF;
        chk("held cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
        chk("held dev_rdata", 32'(dev_rdata), 32'(exp_dev_rd));

        // Address change after capture must not reach the RAM.
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0005; cpu_wdata = 16'h7777;
        step();
        cpu_addr = 13'h1FFF;
        cpu_wdata = 16'h0BAD;
        #1;
        chk("late addr mem_addr", 32'(mem_addr), 32'(13'h0005));
        chk("late addr mem_wdata", 32'(mem_wdata), 32'(16'h7777));
        step();
        chk("late addr ack", 32'(cpu_ack), 32'(1));
        cpu_req = 0;
        step();
        access(1'b0, 1'b0, 13'h0005, 16'h0000, 16'h7777, "late rd 5");
        access(1'b1, 1'b0, 13'h1FFF, 16'h0000, 16'hABCD, "late rd 1fff");

        // Reset asserted while the strobe is on the RAM.
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0020; cpu_wdata = 16'h3333;
        step();
        chk("rst grant mem_en", 32'(mem_en), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst async mem_en", 32'(mem_en), 32'(0));
        chk("rst async owner", 32'(owner), 32'(0));
        chk("rst async acks", 32'({cpu_ack, dev_ack}), 32'(0));
        step();
        reset = 1'b0;
        exp_cpu_rd = '0;
        exp_dev_rd = '0;
        step();
        chk("post rst strobe", 32'({mem_en, mem_we}), 32'(3));
        chk("post rst owner", 32'(owner), 32'(1));
        step();
        chk("post rst ack", 32'(cpu_ack), 32'(1));
        chk("post rst dev_ack", 32'(dev_ack), 32'(0));
        cpu_req = 0;
        step();
        access(1'b0, 1'b0, 13'h0020, 16'h0000, 16'h3333, "post rst rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
